// File: rtl/uart_rx_vote_sampler.sv
// uart_rx_vote_sampler
// Oversampling majority sampler for the UART receiver. Synchronises the raw
// line, takes an odd number of samples centred on the bit midpoint and emits a
// registered decision, a one-cycle valid strobe and a not-unanimous flag.
module uart_rx_vote_sampler #(
  parameter int PRESCALE_W  = 6,
  parameter int NSAMP       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  samp_en,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  sampled_bit,
  output logic                  bit_valid,
  output logic                  noise_flag,
  output logic                  cfg_err
);

  localparam int HALF  = (NSAMP - 1) / 2;
  localparam int CNT_W = $clog2(NSAMP + 1);
  localparam int POS_W = PRESCALE_W + 1;

  localparam logic [POS_W-1:0] HALF_P  = POS_W'(HALF);
  localparam logic [CNT_W-1:0] NSAMP_C = CNT_W'(NSAMP);

  // Synchroniser
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  // Window geometry
  logic [POS_W-1:0] mid;
  logic [POS_W-1:0] start;
  logic [POS_W-1:0] last_pos;
  logic [CNT_W-1:0] ne;

  // Capture state
  logic [CNT_W-1:0]      idx;
  logic [CNT_W-1:0]      ones;
  logic [PRESCALE_W-1:0] last_edge;
  logic                  last_vld;

  // Capture decode
  logic [POS_W-1:0] edge_p;
  logic [POS_W-1:0] next_pos;
  logic             active;
  logic             repeat_edge;
  logic             hit_start;
  logic             hit_next;
  logic             capture;
  logic             done;
  logic [CNT_W-1:0] base;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] total;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign cfg_err = (prescale < PRESCALE_W'(2));

  // Shift the raw line through the synchroniser; reset loads the idle level.
  // NOTE: every clocked block uses non-blocking assignments so all flops
  // update together and no read depends on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= rx_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Centre the window on the midpoint; shrink to one sample when it cannot fit.
  // NOTE: every combinational output gets a default first so no path leaves
  // a variable unassigned and infers a latch.
  always_comb begin
    mid      = POS_W'(prescale >> 1) - POS_W'(1);
    ne       = CNT_W'(1);
    start    = mid;
    if (mid >= HALF_P) begin
      ne    = NSAMP_C;
      start = mid - HALF_P;
    end
    last_pos = start + POS_W'(ne) - POS_W'(1);
  end

  // Decide whether this cycle takes a sample and what the running count becomes.
  always_comb begin
    edge_p      = POS_W'(edge_cnt);
    next_pos    = start + POS_W'(idx);
    active      = samp_en && !cfg_err;
    // A position already seen last cycle is not sampled a second time.
    repeat_edge = last_vld && (edge_cnt == last_edge);
    hit_start   = active && !repeat_edge && (edge_p == start);
    hit_next    = active && !repeat_edge && !hit_start && (idx != '0) && (edge_p == next_pos);
    capture     = hit_start || hit_next;
    done        = capture && (edge_p == last_pos);
    base        = hit_start ? '0 : ones;
    sum         = {1'b0, base} + (CNT_W+1)'(rx_s);
    total       = (sum > (CNT_W+1)'(NSAMP)) ? NSAMP_C : sum[CNT_W-1:0];
  end

  // Advance the window, and on its last sample register the vote and strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      ones        <= '0;
      last_edge   <= '0;
      last_vld    <= 1'b0;
      sampled_bit <= 1'b0;
      noise_flag  <= 1'b0;
      bit_valid   <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      last_edge <= edge_cnt;
      last_vld  <= active;
      if (!samp_en) begin
        idx  <= '0;
        ones <= '0;
      end else if (done) begin
        idx         <= '0;
        ones        <= '0;
        sampled_bit <= (total > (ne >> 1));
        noise_flag  <= (total != '0) && (total != ne);
        bit_valid   <= 1'b1;
      end else if (capture) begin
        idx  <= hit_start ? CNT_W'(1) : idx + CNT_W'(1);
        ones <= total;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_vote_sampler.sv
// Directed bench for uart_rx_vote_sampler. Three instances share stimulus:
// [0] NSAMP=5/SYNC=2, [1] NSAMP=3/SYNC=2, [2] NSAMP=5/SYNC=3. Each cycle's
// stimulus lists the value the synchroniser should deliver (rx_s); the raw
// line of each instance is driven that many cycles ahead. In raw mode the
// listed value is driven straight onto rx_in of every instance.
module tb_uart_rx_vote_sampler;

  localparam int PW = 6;
  localparam int MAXN = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    rx_in_v;
  logic [PW-1:0] prescale;
  logic          samp_en;
  logic [PW-1:0] edge_cnt;
  logic [2:0]    bv, sb, nf, ce;

  int n_tests = 0;
  int n_fail  = 0;

  int   e_arr   [MAXN];
  bit   en_arr  [MAXN];
  bit   rxs_arr [MAXN];
  bit   rst_arr [MAXN];
  int   n;

  int         vcnt [3];
  int         vat  [3];
  int         longp[3];
  logic [2:0] prev_bv;

  always #5 clk = ~clk;

  uart_rx_vote_sampler #(.PRESCALE_W(PW), .NSAMP(5), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst(rst), .rx_in(rx_in_v[0]), .prescale(prescale), .samp_en(samp_en),
    .edge_cnt(edge_cnt), .sampled_bit(sb[0]), .bit_valid(bv[0]), .noise_flag(nf[0]), .cfg_err(ce[0]));

  uart_rx_vote_sampler #(.PRESCALE_W(PW), .NSAMP(3), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst(rst), .rx_in(rx_in_v[1]), .prescale(prescale), .samp_en(samp_en),
    .edge_cnt(edge_cnt), .sampled_bit(sb[1]), .bit_valid(bv[1]), .noise_flag(nf[1]), .cfg_err(ce[1]));

  uart_rx_vote_sampler #(.PRESCALE_W(PW), .NSAMP(5), .SYNC_STAGES(3)) dut2 (
    .clk(clk), .rst(rst), .rx_in(rx_in_v[2]), .prescale(prescale), .samp_en(samp_en),
    .edge_cnt(edge_cnt), .sampled_bit(sb[2]), .bit_valid(bv[2]), .noise_flag(nf[2]), .cfg_err(ce[2]));

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    n = 0;
    for (int i = 0; i < MAXN; i++) begin
      e_arr[i] = 0; en_arr[i] = 1'b0; rxs_arr[i] = 1'b1; rst_arr[i] = 1'b0;
    end
  endtask

  task automatic add(input int e, input bit en, input bit rxs);
    e_arr[n] = e; en_arr[n] = en; rxs_arr[n] = rxs; n++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) add(0, 1'b0, 1'b1);
  endtask

  task automatic window(input int ps, input logic [15:0] pat);
    for (int e = 0; e < ps; e++) add(e, 1'b1, pat[e]);
  endtask

  function automatic bit look(input int k);
    return (k < n) ? rxs_arr[k] : 1'b1;
  endfunction

  // Replays the stimulus list; logs valid pulses, the edge_cnt that produced
  // them, and any strobe that stays high for two observations.
  task automatic play(input bit raw);
    for (int i = 0; i < 3; i++) begin
      vcnt[i] = 0; vat[i] = -1;
    end
    prev_bv = '0;
    for (int t = 0; t <= n; t++) begin
      @(negedge clk);
      if (t > 0) begin
        for (int i = 0; i < 3; i++) begin
          if (bv[i]) begin
            vcnt[i]++;
            vat[i] = e_arr[t-1];
            if (prev_bv[i]) longp[i]++;
          end
        end
      end
      prev_bv = bv;
      if (t < n) begin
        edge_cnt   = e_arr[t][PW-1:0];
        samp_en    = en_arr[t];
        rx_in_v[0] = raw ? rxs_arr[t] : look(t + 2);
        rx_in_v[1] = raw ? rxs_arr[t] : look(t + 2);
        rx_in_v[2] = raw ? rxs_arr[t] : look(t + 3);
        if (rst_arr[t] && !rst) begin
          rst = 1'b1;
          #1;
          check("midrst_valid", bv[0], 0);
          check("midrst_bit",   sb[0], 0);
          check("midrst_noise", nf[0], 0);
        end
        rst = rst_arr[t];
      end else begin
        samp_en = 1'b0;
        rst     = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) longp[i] = 0;
    rst      = 1'b1;
    rx_in_v  = '1;
    prescale = PW'(16);
    samp_en  = 1'b0;
    edge_cnt = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", bv[0], 0);
    check("rst_bit",   sb[0], 0);
    check("rst_noise", nf[0], 0);
    check("cfg_ps16",  ce[0], 0);
    prescale = PW'(1);
    #1 check("cfg_ps1", ce[0], 1);
    prescale = PW'(2);
    #1 check("cfg_ps2", ce[0], 0);
    prescale = PW'(16);
    @(negedge clk);
    rst = 1'b0;

    // Nominal window, line idle high.
    clr(); idle(4); window(16, 16'hFFFF); play(1'b0);
    check("nom_cnt",   vcnt[0], 1);
    check("nom_at",    vat[0],  9);
    check("nom_bit",   sb[0],   1);
    check("nom_noise", nf[0],   0);
    check("nom3_at",   vat[1],  8);
    check("nom_s3_at", vat[2],  9);

    // Majority with noise: 1,0,1,0,0 then 1,1,0,1,1 at edges 5..9.
    clr(); idle(4); window(16, 16'hFCBF); play(1'b0);
    check("noise1_cnt",   vcnt[0], 1);
    check("noise1_bit",   sb[0],   0);
    check("noise1_noise", nf[0],   1);
    clr(); idle(4); window(16, 16'hFF7F); play(1'b0);
    check("noise2_bit",   sb[0],   1);
    check("noise2_noise", nf[0],   1);
    check("noise2_s3_bit", sb[2],  1);

    // Degraded single sample (prescale=4): edge 1 held three cycles.
    prescale = PW'(4);
    clr(); idle(4);
    add(0, 1'b1, 1'b1); add(1, 1'b1, 1'b0); add(1, 1'b1, 1'b0); add(1, 1'b1, 1'b0);
    add(2, 1'b1, 1'b1); add(3, 1'b1, 1'b1);
    play(1'b0);
    check("deg_cnt",   vcnt[0], 1);
    check("deg_at",    vat[0],  1);
    check("deg_bit",   sb[0],   0);
    check("deg_noise", nf[0],   0);
    check("deg3_bit",  sb[1],   1);

    // prescale=1: configuration error, no sampling.
    prescale = PW'(1);
    clr(); idle(2);
    for (int i = 0; i < 6; i++) add(0, 1'b1, 1'b0);
    play(1'b0);
    check("ps1_cfg",  ce[0],   1);
    check("ps1_cnt0", vcnt[0], 0);
    check("ps1_cnt1", vcnt[1], 0);

    // Enable drop after edge 2 (NSAMP=3, prescale=8: window 2..4).
    prescale = PW'(8);
    clr(); idle(4);
    add(0, 1'b1, 1'b0); add(1, 1'b1, 1'b0); add(2, 1'b1, 1'b0);
    for (int e = 3; e < 8; e++) add(e, 1'b0, 1'b0);
    play(1'b0);
    check("drop_cnt",  vcnt[1], 0);
    check("drop_hold", sb[1],   1);
    clr(); idle(4); window(8, 16'h0000); play(1'b0);
    check("reen_cnt",   vcnt[1], 1);
    check("reen_at",    vat[1],  4);
    check("reen_bit",   sb[1],   0);
    check("reen_noise", nf[1],   0);
    check("reen5_at",   vat[0],  5);

    // Repeated edge 2, then skip 3: no strobe.
    clr(); idle(4);
    add(0, 1'b1, 1'b1); add(1, 1'b1, 1'b1);
    add(2, 1'b1, 1'b1); add(2, 1'b1, 1'b1); add(2, 1'b1, 1'b1);
    for (int e = 4; e < 8; e++) add(e, 1'b1, 1'b1);
    play(1'b0);
    check("skip_cnt", vcnt[1], 0);
    // Clean 2,3,4 with edge 3 repeated: samples 1,0,1.
    clr(); idle(4);
    add(0, 1'b1, 1'b1); add(1, 1'b1, 1'b1); add(2, 1'b1, 1'b1);
    add(3, 1'b1, 1'b0); add(3, 1'b1, 1'b0); add(3, 1'b1, 1'b0);
    for (int e = 4; e < 8; e++) add(e, 1'b1, 1'b1);
    play(1'b0);
    check("clean_cnt",   vcnt[1], 1);
    check("clean_at",    vat[1],  4);
    check("clean_bit",   sb[1],   1);
    check("clean_noise", nf[1],   1);

    // Reset in the middle of a 5-sample window (edges 7 and 8).
    prescale = PW'(16);
    clr(); idle(4); window(16, 16'hFFFF);
    rst_arr[4 + 7] = 1'b1;
    rst_arr[4 + 8] = 1'b1;
    play(1'b0);
    check("rstwin_cnt", vcnt[0], 0);
    clr(); idle(4); window(16, 16'hFF7F); play(1'b0);
    check("post_rst_cnt",   vcnt[0], 1);
    check("post_rst_at",    vat[0],  9);
    check("post_rst_bit",   sb[0],   1);
    check("post_rst_noise", nf[0],   1);

    // Raw line low for 5 cycles: only a 3-stage synchroniser lines it up
    // exactly with edges 5..9; the 2-stage copy sees a 1 at edge 9.
    clr(); idle(4); window(16, 16'hFFFF);
    for (int t = 6; t <= 10; t++) rxs_arr[t] = 1'b0;
    play(1'b1);
    check("s3_cnt",   vcnt[2], 1);
    check("s3_at",    vat[2],  9);
    check("s3_bit",   sb[2],   0);
    check("s3_noise", nf[2],   0);
    check("s2_bit",   sb[0],   0);
    check("s2_noise", nf[0],   1);

    for (int i = 0; i < 3; i++) check($sformatf("pulse_width_%0d", i), longp[i], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
